bht_next_pc: RTL
================

// Module: bht_next_pc
// PURPOSE
//  Next-PC selector with a dynamic branch predictor. Replaces the static prediction input.
//  - Sits in the IF stage.
//  - Holds a branch history table (BHT) of saturating counters, indexed from the fetch PC.
//  - Drives next_pc, fallback_pc and prediction into IF/ID.
//  - Trains the table from branch outcomes resolved in EXE and flags mispredictions.
// PARAMETERS
//  XLEN        32  address/data width
//  BHT_ENTRIES 64  table depth; must be a power of 2; IDX_W = $clog2(BHT_ENTRIES)
//  CTR_BITS    2   width of each saturating counter (1..4)
//  GHR_BITS    6   global history length; used only with GSHARE_EN; must be <= IDX_W
// PORTS
//  clk             in  1      rising-edge clock
//  rst_n           in  1      synchronous active-low reset
//  branch          in  2      00 non-flow, 01 branch, 10 jal, 11 jalr (instruction in IF)
//  pc_out          in  XLEN   current fetch PC
//  add_pc_4_out    in  XLEN   pc_out + 4
//  add_branch_out  in  XLEN   branch target
//  add_jal_out     in  XLEN   jal target
//  add_jalr_out    in  XLEN   jalr target
//  exe_valid       in  1      a conditional branch resolves in EXE this cycle
//  exe_taken       in  1      resolved direction
//  exe_prediction  in  1      direction predicted for it, carried down the pipe
//  exe_idx         in  IDX_W  BHT index used at its lookup, carried down the pipe
//  exe_fallback_pc in  XLEN   fallback_pc carried down the pipe
//  next_pc         out XLEN   PC to fetch next cycle
//  fallback_pc     out XLEN   recovery PC to carry with the branch
//  prediction      out 1      predicted direction (1 = taken)
//  pred_idx        out IDX_W  BHT index used for this lookup
//  misprediction   out 1      exe_valid & (exe_taken != exe_prediction)
//  branch_cnt      out 32     resolved-branch count
//  mispred_cnt     out 32     misprediction count
// BEHAVIOUR
//  Lookup (combinational, zero latency):
//  - pred_idx = pc_out[IDX_W+1:2].
//  - prediction = MSB of bht[pred_idx]; forced to 0 when branch != 01.
//  - fallback_pc = 32'h00000013 (NOP) unless branch == 01.
//  next_pc priority:
//  - misprediction: next_pc = exe_fallback_pc; all other sources are ignored.
//  - branch == 00: next_pc = add_pc_4_out.
//  - branch == 01, prediction = 0: next_pc = add_pc_4_out, fallback_pc = add_branch_out.
//  - branch == 01, prediction = 1: next_pc = add_branch_out, fallback_pc = add_pc_4_out.
//  - branch == 10: next_pc = add_jal_out.
//  - branch == 11: next_pc = add_jalr_out.
//  Update (registered, on the clk edge when exe_valid == 1):
//  - Taken: bht[exe_idx] += 1, saturating at 2^CTR_BITS-1.
//  - Not taken: bht[exe_idx] -= 1, saturating at 0.
//  - The new value is visible to lookups from the next cycle.
//  - Same-cycle lookup of the entry being written returns the old value (no bypass).
//  - branch_cnt += 1 on every exe_valid; mispred_cnt += 1 on every misprediction.
//  - Both counters wrap modulo 2^32.
//  - Updates and counting are unaffected by the value of branch.
//  Reset (rst_n == 0 at the clk edge):
//  - Every BHT entry is set to weakly-not-taken, 2^(CTR_BITS-1)-1 (2'b01 for CTR_BITS = 2).
//  - Both counters are set to 0.
//  - An update presented in the reset cycle is dropped.
//  - Combinational outputs follow their inputs during reset; the table reads the reset value from the next cycle.
//  misprediction is purely combinational and is 0 whenever exe_valid == 0.
// CONFIGURATION
//  GSHARE_EN defined:
//  - A GHR_BITS global history register, reset to 0, is added.
//  - On each exe_valid it shifts left with exe_taken entering the LSB (non-speculative).
//  - pred_idx = pc_out[IDX_W+1:2] XOR {zero pad, ghr}.
//  - Updates still use exe_idx.
//  GSHARE_EN undefined: no GHR exists; indexing is PC-only as above.
// STRUCTURE
//  Package bp_pkg: BR_NONE / BR_BRANCH / BR_JAL / BR_JALR encodings, NOP_INSN = 32'h00000013.
//  Sub-module sat_counter: parametrised CTR_BITS up/down saturating step function.
//  Used by the BHT update.
// TESTING
//  (Defaults unless noted.)
//  1. Reset, then branch = 01 at pc 0x100 -> prediction = 0, next_pc = 0x104, fallback_pc = branch target.
//  2. Two exe_valid taken updates to idx 0 -> the lookup at pc 0x0 predicts taken from the cycle after the 1st update.
//     Further taken updates keep the counter at 2'b11.
//  3. exe_valid = 1, exe_taken = 1, exe_prediction = 0, exe_fallback_pc = 0x2000, branch = 10 -> misprediction = 1, next_pc = 0x2000.
//     mispred_cnt increments by 1.
//  4. Update and lookup of the same index in one cycle -> the lookup sees the old counter; the next cycle sees the new one.
//  5. Assert rst_n = 0 after training idx 5 to 2'b11 -> idx 5 reads 2'b01 and both counters read 0 after the reset cycle.
//  6. With GSHARE_EN, after taken, taken history (ghr = 6'b000011), pc 0x0 -> pred_idx = 3.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared encodings for the next-PC selector and branch predictor.
package bp_pkg;

    // Control-flow class of the instruction currently in IF.
    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_BRANCH = 2'b01,
        BR_JAL    = 2'b10,
        BR_JALR   = 2'b11
    } br_type_e;

    // Canonical NOP (addi x0, x0, 0), used as the "no recovery needed" fallback.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Up/down saturating step for one branch history counter.
module sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] value,
    input  logic                up,
    output logic [CTR_BITS-1:0] next_value
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

    // Step toward strongly-taken or strongly-not-taken, holding at either end.
    always_comb begin
        next_value = value;
        if (up) begin
            if (value != CTR_MAX) next_value = value + CTR_BITS'(1);
        end else begin
            if (value != CTR_MIN) next_value = value - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/bht_next_pc.sv
// Next-PC selector for IF with a table of saturating direction counters.
// Lookup is combinational from the fetch PC; training comes from EXE.
// Optional macro GSHARE_EN folds a non-speculative global history register
// into the lookup index.
module bht_next_pc
    import bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int GHR_BITS    = 6,
    localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       branch,
    input  logic [XLEN-1:0]  pc_out,
    input  logic [XLEN-1:0]  add_pc_4_out,
    input  logic [XLEN-1:0]  add_branch_out,
    input  logic [XLEN-1:0]  add_jal_out,
    input  logic [XLEN-1:0]  add_jalr_out,
    input  logic             exe_valid,
    input  logic             exe_taken,
    input  logic             exe_prediction,
    input  logic [IDX_W-1:0] exe_idx,
    input  logic [XLEN-1:0]  exe_fallback_pc,
    output logic [XLEN-1:0]  next_pc,
    output logic [XLEN-1:0]  fallback_pc,
    output logic             prediction,
    output logic [IDX_W-1:0] pred_idx,
    output logic             misprediction,
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispred_cnt
);

    // Weakly-not-taken: just below the taken threshold.
    localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0] bht [BHT_ENTRIES];
    logic [CTR_BITS-1:0] upd_old;
    logic [CTR_BITS-1:0] upd_new;
    logic [IDX_W-1:0]    pc_idx;
    br_type_e            br_type;

    // Only the word-index bits of the fetch PC feed the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_out[XLEN-1:IDX_W+2], pc_out[1:0]};

    assign pc_idx  = pc_out[IDX_W+1:2];
    assign br_type = br_type_e'(branch);

`ifdef GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    // History shifts only on resolved branches, so it never needs repair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (exe_valid) begin
            ghr <= GHR_BITS'({ghr, exe_taken});
        end
    end

    assign pred_idx = pc_idx ^ IDX_W'(ghr);
`else
    localparam int unused_ghr_bits = GHR_BITS;

    assign pred_idx = pc_idx;
`endif

    assign upd_old = bht[exe_idx];

    sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_counter (
        .value      (upd_old),
        .up         (exe_taken),
        .next_value (upd_new)
    );

    // Table training; a write lands at the edge, so same-cycle lookups see the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_RESET;
            end
        end else if (exe_valid) begin
            bht[exe_idx] <= upd_new;
        end
    end

    // Resolved-branch and misprediction statistics, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (exe_valid)     branch_cnt  <= branch_cnt + 32'd1;
            if (misprediction) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    assign misprediction = exe_valid & (exe_taken != exe_prediction);

    // Direction lookup and next-PC selection; a misprediction redirect overrides fetch.
    always_comb begin
        prediction  = 1'b0;
        fallback_pc = XLEN'(NOP_INSN);
        next_pc     = add_pc_4_out;
        unique case (br_type)
            BR_NONE: begin
                next_pc = add_pc_4_out;
            end
            BR_BRANCH: begin
                prediction = bht[pred_idx][CTR_BITS-1];
                if (prediction) begin
                    next_pc     = add_branch_out;
                    fallback_pc = add_pc_4_out;
                end else begin
                    next_pc     = add_pc_4_out;
                    fallback_pc = add_branch_out;
                end
            end
            BR_JAL: begin
                next_pc = add_jal_out;
            end
            BR_JALR: begin
                next_pc = add_jalr_out;
            end
            default: begin
                next_pc = add_pc_4_out;
            end
        endcase
        if (misprediction) begin
            next_pc = exe_fallback_pc;
        end
    end

endmodule
